// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INST_BYTES   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        FULL  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_unit.sv
// Fetch front end: PC, single-outstanding imem request, one-entry output buffer,
// and squash/restart on a taken branch from execute.
module fetch_redirect_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            flush,
    output logic            misalign
);

    fetch_state_e    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic [XLEN-1:0] req_addr_reg, req_addr_next;
    logic            out_valid_reg, out_valid_next;
    logic [XLEN-1:0] out_inst_reg, out_inst_next;
    logic [XLEN-1:0] out_pc_reg, out_pc_next;
    logic            flush_reg, flush_next;
    logic            misalign_reg, misalign_next;

    logic            redirect;
    logic [XLEN-1:0] target_aligned;
    logic [XLEN-1:0] fetch_pc;

    assign redirect       = br_valid & br_taken;
    assign target_aligned = {br_target[XLEN-1:2], 2'b00};
    // A redirect arriving in the same cycle a new request is formed wins over the stale pc.
    assign fetch_pc       = redirect ? target_aligned : pc_reg;

    always_comb begin
        state_next     = state_reg;
        pc_next        = redirect ? target_aligned : pc_reg;
        req_addr_next  = req_addr_reg;
        out_valid_next = out_valid_reg;
        out_inst_next  = out_inst_reg;
        out_pc_next    = out_pc_reg;
        flush_next     = redirect;
        misalign_next  = redirect & (|br_target[1:0]);

        case (state_reg)
            IDLE: begin
                state_next    = WAIT;
                req_addr_next = fetch_pc;
            end
            WAIT: begin
                if (imem_ready) begin
                    if (redirect) begin
                        req_addr_next = target_aligned;
                    end else begin
                        out_inst_next  = imem_rdata;
                        out_pc_next    = req_addr_reg;
                        out_valid_next = 1'b1;
                        pc_next        = pc_reg + XLEN'(INST_BYTES);
                        state_next     = FULL;
                    end
                end else if (redirect) begin
                    // Memory cannot be abandoned mid-request; wait out the wrong-path beat.
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (imem_ready) begin
                    req_addr_next = fetch_pc;
                    state_next    = WAIT;
                end
            end
            FULL: begin
                if (redirect) begin
                    out_valid_next = 1'b0;
                    req_addr_next  = target_aligned;
                    state_next     = WAIT;
                end else if (out_ready) begin
                    out_valid_next = 1'b0;
                    req_addr_next  = pc_reg;
                    state_next     = WAIT;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            pc_reg        <= RESET_PC;
            req_addr_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_inst_reg  <= '0;
            out_pc_reg    <= '0;
            flush_reg     <= 1'b0;
            misalign_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            req_addr_reg  <= req_addr_next;
            out_valid_reg <= out_valid_next;
            out_inst_reg  <= out_inst_next;
            out_pc_reg    <= out_pc_next;
            flush_reg     <= flush_next;
            misalign_reg  <= misalign_next;
        end
    end

    assign imem_req  = (state_reg == WAIT) || (state_reg == DRAIN);
    assign imem_addr = req_addr_reg;
    assign out_valid = out_valid_reg;
    assign out_inst  = out_inst_reg;
    assign out_pc    = out_pc_reg;
    assign flush     = flush_reg;
    assign misalign  = misalign_reg;

endmodule

// File: doc/fetch_redirect_unit.md
Name: fetch_redirect_unit

Overview:
- Instruction-fetch front end and the consumer of the branch decision (br_taken) plus branch target from the execute stage.
- Holds the PC and fetches over a req/ready instruction-memory handshake.
- Presents one buffered instruction through a valid/ready port to decode.
- On a taken branch, squashes wrong-path work (including an in-flight memory request) and restarts fetch at the target.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
br_valid  in  1  execute stage has resolved a branch/jump this cycle
br_taken  in  1  resolved branch taken (qualified by br_valid)
br_target  in  XLEN  taken-branch target address
imem_req  out  1  instruction-memory request
imem_addr  out  XLEN  request address
imem_ready  in  1  memory returns data this cycle (completes request)
imem_rdata  in  XLEN  instruction word, valid with imem_ready
out_valid  out  1  buffered instruction available
out_ready  in  1  decode accepts instruction
out_inst  out  XLEN  instruction word
out_pc  out  XLEN  PC of out_inst
flush  out  1  one-cycle squash pulse to downstream stages
misalign  out  1  one-cycle pulse: br_target[1:0] != 0

Behaviour:
- All state is registered; reset is synchronous, active-high.
- Reset values: pc=RESET_PC, state=IDLE, out_valid=0, out_inst=0, out_pc=0, flush=0, misalign=0, imem_req=0, req_addr=0.
- imem_req and imem_addr are decoded from state: imem_req=1 only in WAIT or DRAIN. imem_addr=req_addr, which is latched from pc on entry to WAIT.
- Memory protocol:
  - Once imem_req rises, imem_req and imem_addr stay stable until the cycle imem_ready=1.
  - Completion happens when imem_req and imem_ready are both 1.
  - imem_ready while imem_req=0 is ignored.
- redirect = br_valid & br_taken. br_taken without br_valid is ignored. br_valid with !br_taken has no effect.
- On redirect: pc <= {br_target[XLEN-1:2],2'b00}; flush=1 next cycle only; misalign=1 next cycle if br_target[1:0]!=0.
- State IDLE (after reset): go to WAIT next cycle, req_addr<=pc.
- State WAIT (imem_req=1, buffer empty):
  - imem_ready & !redirect: out_inst<=imem_rdata, out_pc<=req_addr, out_valid<=1, pc<=pc+4, go to FULL.
  - imem_ready & redirect: discard data, req_addr<=target, stay in WAIT (new request next cycle).
  - !imem_ready & redirect: go to DRAIN; req_addr unchanged.
- State DRAIN (imem_req=1, old address):
  - imem_ready: discard data, req_addr<=pc, go to WAIT.
  - A further redirect updates pc and raises flush/misalign again; remain in DRAIN until imem_ready.
- State FULL (imem_req=0, out_valid=1):
  - out_inst and out_pc stay stable while !out_ready.
  - out_ready & !redirect: out_valid<=0, req_addr<=pc, go to WAIT.
  - redirect (regardless of out_ready): out_valid<=0, req_addr<=target, go to WAIT. Any same-cycle handoff is wrong-path and is covered by flush.
- Throughput: at most one instruction per 2 cycles (capture cycle, then a fresh request after drain). Zero-wait memory gives out_valid on alternating cycles.
- pc increments modulo 2^XLEN; 0xFFFF_FFFC+4 wraps to 0.
- Reset asserted in any state (including DRAIN mid-request) forces the reset values next edge. The memory shares rst and abandons the request.

Decomposition:
- fetch_pkg holds: fetch_state_e enum {IDLE, WAIT, DRAIN, FULL}, localparam INST_BYTES=4, and the XLEN default.
- No sub-module. The PC register, request register and output buffer are inline in one always_ff block with a next-state always_comb.

Test Plan:
1. Reset deassert with imem_ready=1 and imem_rdata=addr^32'hA5A5_A5A5, out_ready=1 -> imem_req rises 1 cycle after IDLE; out_pc sequence 0x0, 0x4, 0x8 on alternating cycles; out_inst matches.
2. Hold out_ready=0 for 5 cycles in FULL with out_pc=0x4 -> out_valid=1, out_inst and out_pc stable, imem_req=0 throughout. Then out_ready=1 -> next req addr 0x8.
3. Request at 0x8 pending (imem_ready=0), then redirect to 0x100 -> flush=1 for one cycle; imem_addr stays 0x8 until imem_ready; that data is not presented; next request addr 0x100; first out_pc=0x100.
4. Redirect to 0x200 in the same cycle imem_ready=1 for addr 0xC -> data dropped, out_valid stays 0, next request addr 0x200, no DRAIN entered.
5. Redirect to 0x40 in FULL with out_ready=1 -> out_valid=0 next cycle, flush=1, next request addr 0x40. br_valid=1 with br_taken=0 -> no flush, sequential fetch continues.
6. Redirect to 0x102 -> misalign=1 one cycle, fetch addr 0x100. rst=1 during DRAIN -> next cycle imem_req=0, out_valid=0, pc=0x0, state IDLE.
